// File: rtl/word_dumper.sv
// word_dumper: walks a small word-addressed memory from address 0 upward and
// streams every 32-bit word out as four bytes, least significant byte first,
// over a valid/ready byte interface. A start pulse in IDLE launches one dump;
// done pulses for one cycle when the last byte has been accepted.
module word_dumper #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } state_t;

    // Highest word address; reaching it on the last byte ends the dump
    // instead of wrapping back to word 0.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [1:0]            idx;
    logic [1:0]            idx_next;
    logic [31:0]           buffer;
    logic [31:0]           buffer_next;

    // State register plus the address, byte index and word buffer it steers.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state  <= IDLE;
            addr   <= '0;
            idx    <= 2'd0;
            buffer <= 32'd0;
        end else begin
            state  <= state_next;
            addr   <= addr_next;
            idx    <= idx_next;
            buffer <= buffer_next;
        end
    end

    // Next-state logic; everything holds unless a state explicitly updates it,
    // which is what keeps the byte stable while the transmitter stalls.
    always_comb begin
        state_next  = state;
        addr_next   = addr;
        idx_next    = idx;
        buffer_next = buffer;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    addr_next  = '0;
                    idx_next   = 2'd0;
                end
            end
            READ: begin
                state_next = LATCH;
            end
            LATCH: begin
                buffer_next = mem_data;
                idx_next    = 2'd0;
                state_next  = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx != 2'd3) begin
                        idx_next = idx + 2'd1;
                    end else if (addr != LAST_ADDR) begin
                        addr_next  = addr + ADDR_WIDTH'(1);
                        state_next = READ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                addr_next  = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte select from the buffered word; only registered values feed it.
    always_comb begin
        tx_data = buffer[7:0];
        case (idx)
            2'd0: tx_data = buffer[7:0];
            2'd1: tx_data = buffer[15:8];
            2'd2: tx_data = buffer[23:16];
            2'd3: tx_data = buffer[31:24];
            default: tx_data = buffer[7:0];
        endcase
    end

    assign mem_addr = addr;
    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_word_dumper.sv
// tb_word_dumper: directed checks of word_dumper with a 4-word registered memory.
module tb_word_dumper;

    logic        CLK;
    logic        reset_n;
    logic        start;
    logic [1:0]  mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int passed;
    int total;

    logic [31:0] mem [4];
    logic [7:0]  exp_bytes [16];
    logic [7:0]  got [$];

    word_dumper #(.ADDR_WIDTH(2)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory with a registered read port
    always @(posedge CLK) mem_data <= mem[mem_addr];

    // Byte collector: a byte moves at the coming edge when valid and ready are both high
    always @(negedge CLK) begin
        if (reset_n && tx_valid && tx_ready) got.push_back(tx_data);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b1;
        tx_ready = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (mem_addr !== 2'd0) $display("[TB] FAIL reset_mem_addr: got %0d expected 0", mem_addr); else passed++;
        reset_n = 1'b1;
        start   = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_idle_hold: got busy %b expected 0", busy); else passed++;
    endtask

    task automatic test_basic();
        int cyc;
        int done_cyc;
        int done_cnt;
        logic [1:0] exp_addr;
        logic [7:0] b;
        got.delete();
        tx_ready = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        done_cnt = 0;
        while (cyc <= 40) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) begin
                total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_start: got %b expected 1", busy); else passed++;
            end
            if (cyc <= 26) begin
                exp_addr = (cyc <= 24) ? 2'((cyc - 1) / 6) : ((cyc == 25) ? 2'd3 : 2'd0);
                total++;
                if (mem_addr !== exp_addr)
                    $display("[TB] FAIL basic_mem_addr cycle %0d: got %0d expected %0d", cyc, mem_addr, exp_addr);
                else passed++;
            end
            if (cyc == 26) begin
                total++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); else passed++;
            end
            tick();
            cyc++;
        end
        total++; if (done_cyc != 25) $display("[TB] FAIL basic_done_cycle: got %0d expected 25", done_cyc); else passed++;
        total++; if (done_cnt != 1) $display("[TB] FAIL basic_done_width: got %0d expected 1", done_cnt); else passed++;
        total++; if (got.size() != 16) $display("[TB] FAIL basic_byte_count: got %0d expected 16", got.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            b = (i < got.size()) ? got[i] : 8'hxx;
            total++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL basic_byte %0d: got %h expected %h", i, b, exp_bytes[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int done_cyc;
        int hold;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [7:0] b;
        got.delete();
        tx_ready = 1'b0;
        start    = 1'b1;
        tick();
        start      = 1'b0;
        cyc        = 1;
        done_cyc   = -1;
        hold       = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        while (cyc <= 100) begin
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (prev_stall) begin
                total++;
                if (tx_valid !== 1'b1) $display("[TB] FAIL bp_valid_hold cycle %0d: got %b expected 1", cyc, tx_valid);
                else passed++;
                total++;
                if (tx_data !== prev_data) $display("[TB] FAIL bp_data_hold cycle %0d: got %h expected %h", cyc, tx_data, prev_data);
                else passed++;
            end
            if (tx_valid === 1'b1) begin
                if (hold < 3) begin
                    tx_ready = 1'b0;
                    hold++;
                end else begin
                    tx_ready = 1'b1;
                    hold = 0;
                end
            end else begin
                tx_ready = 1'b0;
            end
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            tick();
            cyc++;
        end
        total++; if (done_cyc != 73) $display("[TB] FAIL bp_done_cycle: got %0d expected 73", done_cyc); else passed++;
        total++; if (got.size() != 16) $display("[TB] FAIL bp_byte_count: got %0d expected 16", got.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            b = (i < got.size()) ? got[i] : 8'hxx;
            total++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL bp_byte %0d: got %h expected %h", i, b, exp_bytes[i]);
            else passed++;
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_start_held();
        int cyc;
        int done_cnt;
        int d1;
        int d2;
        logic [7:0] b;
        got.delete();
        tx_ready = 1'b1;
        start    = 1'b1;
        tick();
        cyc      = 1;
        done_cnt = 0;
        d1       = -1;
        d2       = -1;
        while (cyc <= 80) begin
            if (cyc == 40) start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (cyc == 26) begin
                total++; if (busy !== 1'b0) $display("[TB] FAIL held_idle_gap: got busy %b expected 0", busy); else passed++;
            end
            if (cyc == 27) begin
                total++; if (busy !== 1'b1) $display("[TB] FAIL held_restart: got busy %b expected 1", busy); else passed++;
            end
            tick();
            cyc++;
        end
        total++; if (done_cnt != 2) $display("[TB] FAIL held_done_count: got %0d expected 2", done_cnt); else passed++;
        total++; if (d1 != 25) $display("[TB] FAIL held_first_done: got %0d expected 25", d1); else passed++;
        total++; if (d2 != 51) $display("[TB] FAIL held_second_done: got %0d expected 51", d2); else passed++;
        total++; if (got.size() != 32) $display("[TB] FAIL held_byte_count: got %0d expected 32", got.size()); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL held_no_queue: got busy %b expected 0", busy); else passed++;
        for (int i = 0; i < 16; i++) begin
            b = (i + 16 < got.size()) ? got[i + 16] : 8'hxx;
            total++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL held_second_byte %0d: got %h expected %h", i, b, exp_bytes[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        int done_cyc;
        logic [7:0] b;
        got.delete();
        tx_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 16) begin
            tick();
            cyc++;
        end
        total++; if (tx_valid !== 1'b1) $display("[TB] FAIL mid_valid_before: got %b expected 1", tx_valid); else passed++;
        total++; if (mem_addr !== 2'd2) $display("[TB] FAIL mid_addr_before: got %0d expected 2", mem_addr); else passed++;
        total++; if (tx_data !== 8'h00) $display("[TB] FAIL mid_data_before: got %h expected 00", tx_data); else passed++;
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        total++; if (tx_valid !== 1'b0) $display("[TB] FAIL mid_valid_after: got %b expected 0", tx_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy_after: got %b expected 0", busy); else passed++;
        total++; if (mem_addr !== 2'd0) $display("[TB] FAIL mid_addr_after: got %0d expected 0", mem_addr); else passed++;
        total++; if (tx_data !== 8'h00) $display("[TB] FAIL mid_data_after: got %h expected 00", tx_data); else passed++;
        total++; if (got.size() != 9) $display("[TB] FAIL mid_bytes_sent: got %0d expected 9", got.size()); else passed++;
        reset_n = 1'b1;
        start   = 1'b0;
        tick();
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("[TB] FAIL mid_stay_idle: got busy %b expected 0", busy); else passed++;
        got.delete();
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        while (cyc <= 40 && done_cyc < 0) begin
            if (done === 1'b1) done_cyc = cyc;
            tick();
            cyc++;
        end
        total++; if (done_cyc != 25) $display("[TB] FAIL mid_redump_done: got %0d expected 25", done_cyc); else passed++;
        total++; if (got.size() != 16) $display("[TB] FAIL mid_redump_count: got %0d expected 16", got.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            b = (i < got.size()) ? got[i] : 8'hxx;
            total++;
            if (b !== exp_bytes[i]) $display("[TB] FAIL mid_redump_byte %0d: got %h expected %h", i, b, exp_bytes[i]);
            else passed++;
        end
        tick();
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        mem[0] = 32'hec000000;
        mem[1] = 32'hf0000000;
        mem[2] = 32'h20000001;
        mem[3] = 32'hf0000000;
        exp_bytes = '{8'h00, 8'h00, 8'h00, 8'hec,
                      8'h00, 8'h00, 8'h00, 8'hf0,
                      8'h01, 8'h00, 8'h00, 8'h20,
                      8'h00, 8'h00, 8'h00, 8'hf0};
        test_reset();
        test_basic();
        test_backpressure();
        test_start_held();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/word_dumper.md
WORD_DUMPER -- requirements
Module: word_dumper

Interface
REQ-001 Parameter: ADDR_WIDTH, default 2, word-address width; dump covers words 0 .. 2**ADDR_WIDTH-1.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 start  input  1  request a full dump; sampled only in IDLE.
REQ-005 mem_addr  output  ADDR_WIDTH  registered word address to the memory read port.
REQ-006 mem_data  input  32  memory read data; valid the cycle after mem_addr is presented (memory registers its output).
REQ-007 tx_data  output  8  byte offered to the byte transmitter.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  transmitter accepts; a byte transfers on any rising edge with tx_valid=1 and tx_ready=1.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-011 done  output  1  one-cycle pulse at dump completion.

Function
REQ-012 The FSM SHALL have states IDLE, READ, LATCH, SEND, DONE.
REQ-013 IDLE: start=1 -> READ with word address=0 and byte index=0; start=0 -> stay.
REQ-014 READ: mem_addr SHALL hold the current word address for one cycle; unconditionally -> LATCH.
REQ-015 LATCH: a 32-bit buffer SHALL capture mem_data; byte index<=0; -> SEND.
REQ-016 SEND: tx_valid=1; tx_data=buffer[8*idx+7:8*idx], i.e. LSB byte first (idx 0 = bits 7:0, idx 3 = bits 31:24).
REQ-017 SEND with tx_ready=0: state, idx, buffer and tx_data SHALL be held unchanged.
REQ-018 SEND with tx_ready=1 and idx<3: idx<=idx+1, stay in SEND.
REQ-019 SEND with tx_ready=1, idx=3, address<2**ADDR_WIDTH-1: address<=address+1 -> READ.
REQ-020 SEND with tx_ready=1, idx=3, address=2**ADDR_WIDTH-1: -> DONE; the address SHALL NOT wrap before the dump ends.
REQ-021 DONE: done=1 for exactly one cycle; address<=0; -> IDLE.
REQ-022 tx_valid, tx_data, busy and done SHALL be decoded from registers only; there SHALL be no combinational path from tx_ready or start to any output.
REQ-023 tx_valid SHALL be 0 in IDLE, READ, LATCH and DONE.
REQ-024 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 With tx_ready held at 1, each word SHALL take exactly 6 cycles (READ 1, LATCH 1, SEND 4).
REQ-026 A full dump SHALL take 6*2**ADDR_WIDTH cycles; done SHALL be high 6*2**ADDR_WIDTH+1 cycles after the start-sampling edge.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force IDLE, mem_addr=0, idx=0, buffer=0, tx_valid=0, tx_data=0, busy=0, done=0, in any state.
REQ-028 reset_n SHALL take priority over start and tx_ready on the same edge.
REQ-029 Reset during SEND SHALL drop tx_valid at that edge; the partially sent word is not resumed.
REQ-030 After release, the block SHALL stay in IDLE until a new start.

Verification
REQ-031 Memory {0:ec000000, 1:f0000000, 2:20000001, 3:f0000000}, tx_ready=1, start pulse -> 16 bytes: 00 00 00 ec 00 00 00 f0 01 00 00 20 00 00 00 f0; done high in cycle 25 after the start edge.
REQ-032 As REQ-031 with tx_ready low for 3 cycles on every byte -> identical byte order; tx_data stable while tx_valid=1 and tx_ready=0; done delayed by exactly 48 cycles.
REQ-033 start held high for 40 cycles -> exactly one dump of 16 bytes, plus one restart if start is still high in IDLE after DONE.
REQ-034 reset_n=0 while SEND is on word 2, idx 1 -> next cycle tx_valid=0, busy=0, mem_addr=0; a new start then dumps from word 0 again.
REQ-035 mem_addr trace with tx_ready=1 -> 0,1,2,3, each held stable through its READ cycle; no access beyond address 3.
